// File: rtl/tt_um_game_of_life.sv
// Conway's Game of Life on an 8x8 torus, TinyTapeout user tile.
// Optional GEN_COUNT_EN adds an 8-bit generation counter viewable on uo_out via uio_in[7].
module tt_um_game_of_life #(
  parameter int SPEED_LOG2 = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int TW = (SPEED_LOG2 > 0) ? SPEED_LOG2 : 1;
  localparam logic [TW-1:0] TMAX = TW'((64'd1 << SPEED_LOG2) - 64'd1);

  logic [7:0][7:0] r_grid;
  logic [TW-1:0]   r_timer;
  logic            r_step_q;

  logic [2:0]      w_addr;
  logic            w_write;
  logic            w_step;
  logic            w_run;
  logic            w_clear;
  logic            w_step_edge;
  logic            w_tick;
  logic            w_gen;
  logic [7:0][7:0] w_next;

  assign w_addr  = uio_in[2:0];
  assign w_write = uio_in[3];
  assign w_step  = uio_in[4];
  assign w_run   = uio_in[5];
  assign w_clear = uio_in[6];

  assign w_step_edge = w_step & ~r_step_q;
  assign w_tick      = w_run & (r_timer == TMAX);
  assign w_gen       = w_step_edge | w_tick;

  // Neighbour indices use 3-bit arithmetic so the wrap-around is free.
  function automatic logic [7:0][7:0] life_step(input logic [7:0][7:0] g);
    logic [7:0][7:0] nx;
    logic [3:0]      n;
    logic [2:0]      ri, ci, rm, rp, cm, cp;
    nx = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        ri = 3'(r);
        ci = 3'(c);
        rm = ri - 3'd1;
        rp = ri + 3'd1;
        cm = ci - 3'd1;
        cp = ci + 3'd1;
        n  = 4'(g[rm][cm]) + 4'(g[rm][ci]) + 4'(g[rm][cp]) +
             4'(g[ri][cm]) +                 4'(g[ri][cp]) +
             4'(g[rp][cm]) + 4'(g[rp][ci]) + 4'(g[rp][cp]);
        nx[ri][ci] = (n == 4'd3) | (g[ri][ci] & (n == 4'd2));
      end
    end
    return nx;
  endfunction

  assign w_next = life_step(r_grid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grid   <= '0;
      r_timer  <= '0;
      r_step_q <= 1'b0;
    end else if (ena) begin
      r_step_q <= w_step;
      if (w_clear) begin
        r_grid  <= '0;
        r_timer <= '0;
      end else if (w_write) begin
        r_grid[w_addr] <= ui_in;
      end else begin
        if (!w_run || r_timer == TMAX) begin
          r_timer <= '0;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
        if (w_gen) begin
          r_grid <= w_next;
        end
      end
    end
  end

`ifdef GEN_COUNT_EN
  logic [7:0] r_gen_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gen_cnt <= 8'd0;
    end else if (ena) begin
      if (w_clear) begin
        r_gen_cnt <= 8'd0;
      end else if (!w_write && w_gen) begin
        r_gen_cnt <= r_gen_cnt + 8'd1;
      end
    end
  end

  assign uo_out = uio_in[7] ? r_gen_cnt : r_grid[w_addr];
`else
  logic w_unused_view;
  assign w_unused_view = uio_in[7];
  assign uo_out = r_grid[w_addr];
`endif

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_game_of_life.sv
// Directed bench for tt_um_game_of_life; runs with a short run period (SPEED_LOG2=2).
module tb_tt_um_game_of_life;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [2:0] addr;
  logic       wr, step, run, clr, view;

  int n_cmp;
  int n_err;

  assign uio_in = {view, clr, run, step, wr, addr};

  tt_um_game_of_life #(.SPEED_LOG2(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // checking
  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected grid packed with row 0 in the low byte.
  task automatic check_grid(input string tag, input logic [63:0] exp);
    for (int r = 0; r < 8; r++) begin
      addr = 3'(r);
      #1;
      check_eq($sformatf("%s row%0d", tag, r), uo_out, exp[r*8 +: 8]);
    end
    addr = 3'd0;
  endtask

  // drivers
  task automatic write_row(input logic [2:0] a, input logic [7:0] d);
    addr  = a;
    ui_in = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
    addr  = 3'd0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    ena   = 1'b1;
    ui_in = 8'h00;
    addr  = 3'd0;
    wr = 1'b0; step = 1'b0; run = 1'b0; clr = 1'b0; view = 1'b0;
    tick();
    tick();
    check_grid("reset", 64'h0);
    check_eq("uio_out", uio_out, 8'h00);
    check_eq("uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Blinker: single step, then back.
    write_row(3'd3, 8'h1C);
    check_grid("blinker load", 64'h0000_0000_1C00_0000);
    pulse_step();
    check_grid("blinker step1", 64'h0000_0008_0808_0000);
    pulse_step();
    check_grid("blinker step2", 64'h0000_0000_1C00_0000);

    // Held-high step advances exactly one generation.
    step = 1'b1;
    tick(); tick(); tick();
    step = 1'b0;
    tick();
    check_grid("step held", 64'h0000_0008_0808_0000);
    do_clear();
    check_grid("clear", 64'h0);

    // Wrap-around block across both edges is a still life.
    write_row(3'd0, 8'h81);
    write_row(3'd7, 8'h81);
    repeat (3) pulse_step();
    check_grid("wrap block", 64'h8100_0000_0000_0081);
    do_clear();

    // Glider returns to its start after 32 generations on the torus.
    write_row(3'd0, 8'h02);
    write_row(3'd1, 8'h04);
    write_row(3'd2, 8'h07);
    pulse_step();
    check_grid("glider gen1", 64'h0000_0000_0206_0500);
    repeat (31) pulse_step();
    check_grid("glider gen32", 64'h0000_0000_0007_0402);
    do_clear();

    // Fully populated grid: every cell has 8 neighbours and dies.
    for (int r = 0; r < 8; r++) write_row(3'(r), 8'hFF);
    pulse_step();
    check_grid("full grid", 64'h0);

    // Write and step together: only the write lands.
    write_row(3'd3, 8'h1C);
    addr  = 3'd5;
    ui_in = 8'h01;
    wr    = 1'b1;
    step  = 1'b1;
    tick();
    wr    = 1'b0;
    step  = 1'b0;
    tick();
    check_grid("write beats step", 64'h0000_0100_1C00_0000);
    do_clear();

    // Run timer: with period 4, three run clocks do nothing, four give one generation.
    write_row(3'd3, 8'h1C);
    run = 1'b1;
    repeat (3) tick();
    run = 1'b0;
    check_grid("run 3 clocks", 64'h0000_0000_1C00_0000);
    tick();
    run = 1'b1;
    repeat (4) tick();
    run = 1'b0;
    check_grid("run 4 clocks", 64'h0000_0008_0808_0000);

    // Clear wins over run.
    run = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    run = 1'b0;
    check_grid("clear with run", 64'h0);

    // Tile disabled: write and step are ignored.
    ena = 1'b0;
    write_row(3'd1, 8'hFF);
    pulse_step();
    ena = 1'b1;
    tick();
    check_grid("ena low", 64'h0);

`ifdef GEN_COUNT_EN
    write_row(3'd3, 8'h1C);
    repeat (5) pulse_step();
    view = 1'b1;
    #1;
    check_eq("gen count 5", uo_out, 8'd5);
    view = 1'b0;
    do_clear();
    view = 1'b1;
    #1;
    check_eq("gen count clear", uo_out, 8'd0);
    view = 1'b0;
`else
    write_row(3'd3, 8'h1C);
    view = 1'b1;
    addr = 3'd3;
    #1;
    check_eq("view ignored", uo_out, 8'h1C);
    view = 1'b0;
    addr = 3'd0;
    do_clear();
`endif

    // Asynchronous reset while running, then release with run low.
    write_row(3'd0, 8'h02);
    write_row(3'd1, 8'h04);
    write_row(3'd2, 8'h07);
    run = 1'b1;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    addr = 3'd2;
    #1;
    check_eq("async reset immediate", uo_out, 8'h00);
    run = 1'b0;
    check_grid("reset mid-run", 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    check_grid("after reset release", 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
